// File: rtl/if2_fetch.sv
// -----------------------------------------------------------------------------
// if2_fetch -- second instruction-fetch stage.
//
// Takes the PC that IF holds on pc_in and issues one instruction-memory read
// for it over a valid/ready request channel, then waits for the single
// response. pause_mem tells IF when to advance: it drops for exactly one cycle
// per completed (or discarded) fetch. The fetched {pc, inst} is registered
// towards ID. A response that arrives under a global stall is parked in a
// one-entry skid buffer until the stall lifts. Redirects from ID (flush) mark
// the in-flight fetch as wrong-path so its data is thrown away.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              synchronous reset, active low
//   pc_in            current PC presented by IF
//   flush            redirect from ID; the fetch in flight is wrong-path
//   stop_all         global pipeline stall
//   pause_mem        to IF; 1 = hold PC, 0 = load next PC this cycle
//   imem_req_valid   memory read request valid
//   imem_req_addr    memory read address
//   imem_req_ready   memory accepts the request
//   imem_resp_valid  read data valid, one pulse per accepted request
//   imem_resp_data   read data
//   id_valid         instruction bundle valid to ID
//   id_pc            PC of id_inst
//   id_inst          fetched instruction (NOP_INST while id_valid=0)
// -----------------------------------------------------------------------------
module if2_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  input  logic              stop_all,
  output logic              pause_mem,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic                req_held_q, req_held_d;  // request shown but not yet accepted
  logic                drop_q, drop_d;          // in-flight fetch is wrong-path
  logic [ADDR_W-1:0]   pc_q, pc_d;              // PC of the outstanding request
  logic [ADDR_W-1:0]   skid_pc_q;
  logic [DATA_W-1:0]   skid_inst_q;

  logic                skid_load;     // park the response during a stall
  logic                deliver_mem;   // hand the live response to ID
  logic                deliver_skid;  // hand the parked response to ID
  logic                flush_hold;    // parked response is wrong-path
  logic                release_pc;    // let IF load its next PC

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d        = state_q;
    req_held_d     = req_held_q;
    drop_d         = drop_q;
    pc_d           = pc_q;
    skid_load      = 1'b0;
    deliver_mem    = 1'b0;
    deliver_skid   = 1'b0;
    flush_hold     = 1'b0;
    release_pc     = 1'b0;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        // A request already on the bus stays there unchanged until accepted,
        // whatever stop_all or flush do meanwhile. A fresh one is only raised
        // outside a stall and captures the PC it was raised for.
        if (req_held_q) begin
          imem_req_valid = 1'b1;
          imem_req_addr  = pc_q;
        end else if (!stop_all) begin
          imem_req_valid = 1'b1;
          imem_req_addr  = pc_in;
          pc_d           = pc_in;
        end

        if (imem_req_valid) begin
          if (imem_req_ready) begin
            req_held_d = 1'b0;
            state_d    = S_WAIT;
          end else begin
            req_held_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || flush) begin
            drop_d     = 1'b0;
            release_pc = 1'b1;
            state_d    = S_REQ;
          end else if (!stop_all) begin
            deliver_mem = 1'b1;
            release_pc  = 1'b1;
            state_d     = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end else if (flush) begin
          // Remember the redirect until the response it poisons shows up.
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (flush) begin
          flush_hold = 1'b1;
          release_pc = 1'b1;
          state_d    = S_REQ;
        end else if (!stop_all) begin
          deliver_skid = 1'b1;
          release_pc   = 1'b1;
          state_d      = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign pause_mem = !release_pc;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_held_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_held_q <= req_held_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: pure datapath registers carry no reset; the control state above
  // guarantees they are written before anything reads them.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (skid_load) begin
      skid_pc_q   <= pc_q;
      skid_inst_q <= imem_resp_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Bundle to ID: a delivery loads it, a stall freezes it, otherwise it
  // falls back to an invalid NOP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= NOP_INST;
    end else if (deliver_mem) begin
      id_valid <= 1'b1;
      id_pc    <= pc_q;
      id_inst  <= imem_resp_data;
    end else if (deliver_skid) begin
      id_valid <= 1'b1;
      id_pc    <= skid_pc_q;
      id_inst  <= skid_inst_q;
    end else if (!stop_all || flush_hold) begin
      id_valid <= 1'b0;
      id_inst  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_if2_fetch.sv
// -----------------------------------------------------------------------------
// tb_if2_fetch -- directed self-checking bench for if2_fetch.
// Expected {pc, inst} bundles are queued when the bench returns a response and
// compared by a monitor on each rising id_valid. Inputs change 1 time unit
// after the rising edge; outputs are sampled around the falling edge.
// -----------------------------------------------------------------------------
module tb_if2_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } bundle_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        stop_all;
  logic        pause_mem;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int hs_before;
  logic prev_valid = 1'b0;
  bundle_t sb[$];

  if2_fetch #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .NOP_INST(NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .flush          (flush),
    .stop_all       (stop_all),
    .pause_mem      (pause_mem),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    bundle_t b;
    b.pc   = pc;
    b.inst = inst;
    sb.push_back(b);
  endtask

  // Count request handshakes and score every new id_valid pulse.
  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) hs_count++;
    if (id_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_id_valid", 64'(id_valid), 64'd0);
      end else begin
        bundle_t e;
        e = sb.pop_front();
        check("sb_id_pc", 64'(id_pc), 64'(e.pc));
        check("sb_id_inst", 64'(id_inst), 64'(e.inst));
      end
    end
    prev_valid = id_valid;
  end

  logic [31:0] b2b_inst [3];

  initial begin
    b2b_inst[0] = 32'h0010_8093;
    b2b_inst[1] = 32'h0020_8113;
    b2b_inst[2] = 32'h0031_0193;

    rst = 1'b0; pc_in = '0; flush = 1'b0; stop_all = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    next(); next();
    mid();
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_pc", 64'(id_pc), 64'd0);
    check("rst_id_inst", 64'(id_inst), 64'(NOP));
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_pause", 64'(pause_mem), 64'd1);

    // First fetch after reset release.
    next(); rst = 1'b1; pc_in = 32'h8000_0000; imem_req_ready = 1'b1;
    mid();
    check("idle_pause", 64'(pause_mem), 64'd1);
    check("idle_req_valid", 64'(imem_req_valid), 64'd0);
    next();
    mid();
    check("t1_req_valid", 64'(imem_req_valid), 64'd1);
    check("t1_req_addr", 64'(imem_req_addr), 64'h8000_0000);
    check("t1_req_pause", 64'(pause_mem), 64'd1);
    next(); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
    push(32'h8000_0000, 32'h0010_0093);
    mid();
    check("t1_resp_pause", 64'(pause_mem), 64'd0);

    // Request held by ready=0 while stop_all toggles.
    next(); imem_resp_valid = 1'b0; pc_in = 32'h8000_0004; hs_before = hs_count;
    mid();
    check("t1_id_valid", 64'(id_valid), 64'd1);
    check("t2_req_valid0", 64'(imem_req_valid), 64'd1);
    check("t2_req_addr0", 64'(imem_req_addr), 64'h8000_0004);
    check("t2_pause0", 64'(pause_mem), 64'd1);
    next(); stop_all = 1'b1; pc_in = 32'h8000_0ff0;
    mid();
    check("t2_req_valid1", 64'(imem_req_valid), 64'd1);
    check("t2_req_addr1", 64'(imem_req_addr), 64'h8000_0004);
    next(); stop_all = 1'b0;
    mid();
    check("t2_req_valid2", 64'(imem_req_valid), 64'd1);
    check("t2_req_addr2", 64'(imem_req_addr), 64'h8000_0004);
    next(); stop_all = 1'b1; imem_req_ready = 1'b1;
    mid();
    check("t2_req_valid3", 64'(imem_req_valid), 64'd1);
    check("t2_req_addr3", 64'(imem_req_addr), 64'h8000_0004);
    next(); stop_all = 1'b0; imem_req_ready = 1'b0; pc_in = 32'h8000_0004;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113;
    push(32'h8000_0004, 32'h0020_0113);
    mid();
    check("t2_one_handshake", 64'(hs_count - hs_before), 64'd1);
    check("t2_resp_pause", 64'(pause_mem), 64'd0);

    // Flush in WAIT: response discarded, next request uses the redirect PC.
    next(); imem_resp_valid = 1'b0; pc_in = 32'h8000_0008; imem_req_ready = 1'b1;
    mid();
    check("t2_id_valid", 64'(id_valid), 64'd1);
    next(); imem_req_ready = 1'b0; flush = 1'b1;
    mid();
    check("t3_flush_pause", 64'(pause_mem), 64'd1);
    next(); flush = 1'b0; pc_in = 32'h8000_0040;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef;
    mid();
    check("t3_drop_pause", 64'(pause_mem), 64'd0);
    next(); imem_resp_valid = 1'b0; imem_req_ready = 1'b1;
    mid();
    check("t3_no_id_valid", 64'(id_valid), 64'd0);
    check("t3_after_pause", 64'(pause_mem), 64'd1);
    check("t3_req_valid", 64'(imem_req_valid), 64'd1);
    check("t3_req_addr", 64'(imem_req_addr), 64'h8000_0040);

    // Response under stall is held in the skid buffer for 4 cycles.
    next(); imem_req_ready = 1'b0; stop_all = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0513;
    push(32'h8000_0040, 32'h0000_0513);
    mid();
    check("t4_stall_pause0", 64'(pause_mem), 64'd1);
    check("t4_stall_id0", 64'(id_valid), 64'd0);
    next(); imem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t4_stall_pause", 64'(pause_mem), 64'd1);
      check("t4_stall_id", 64'(id_valid), 64'd0);
      next();
    end
    stop_all = 1'b0;
    mid();
    check("t4_release_pause", 64'(pause_mem), 64'd0);

    // Back-to-back fetches with a zero-wait memory.
    next(); pc_in = 32'h8000_0000; imem_req_ready = 1'b1;
    mid();
    check("t4_id_inst", 64'(id_inst), 64'h0000_0513);
    check("t4_after_pause", 64'(pause_mem), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        next(); imem_resp_valid = 1'b0; imem_req_ready = 1'b1;
        pc_in = 32'h8000_0000 + 32'(4 * i);
        mid();
      end
      check("t5_req_addr", 64'(imem_req_addr), 64'(32'h8000_0000 + 32'(4 * i)));
      next(); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = b2b_inst[i];
      push(32'h8000_0000 + 32'(4 * i), b2b_inst[i]);
      mid();
      check("t5_resp_pause", 64'(pause_mem), 64'd0);
    end

    // Reset while waiting for a response.
    next(); imem_resp_valid = 1'b0; pc_in = 32'h8000_0100; imem_req_ready = 1'b1;
    mid();
    check("t5_last_id_valid", 64'(id_valid), 64'd1);
    next(); imem_req_ready = 1'b0; rst = 1'b0;
    mid();
    next();
    mid();
    check("t6_id_valid", 64'(id_valid), 64'd0);
    check("t6_req_valid", 64'(imem_req_valid), 64'd0);
    check("t6_pause", 64'(pause_mem), 64'd1);
    check("t6_id_inst", 64'(id_inst), 64'(NOP));

    // The forgotten response shows up after reset and must be ignored.
    next(); rst = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hbad0_bad0;
    mid();
    check("t6_stale_pause", 64'(pause_mem), 64'd1);
    next(); imem_resp_valid = 1'b0; pc_in = 32'h8000_0200; imem_req_ready = 1'b1;
    mid();
    check("t6_stale_id_valid", 64'(id_valid), 64'd0);
    check("t6_req_addr", 64'(imem_req_addr), 64'h8000_0200);
    next(); imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0040_0213;
    push(32'h8000_0200, 32'h0040_0213);
    mid();
    next(); imem_resp_valid = 1'b0;
    mid();
    check("t6_id_valid_after", 64'(id_valid), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
